clock_display_driver: RTL and testbench
=======================================

// Module: clock_display_driver
// PURPOSE
//  Downstream of the alarm clock core: consumes the six BCD time digits and Alarm, drives a 6-digit
//  multiplexed common-anode 7-segment display. Digits are frozen once per scan frame so no digit tears.
//  A set Alarm blinks the whole display. Sits between the clock core and the board I/O pins.
// PARAMETERS
//  SCAN_DIV      4  clk cycles per digit slot (>=2); one scan tick every SCAN_DIV cycles
//  BLINK_FRAMES  8  full 6-digit frames per blink half-period (>=1)
// PORTS
//  clk        in   1  system clock; single clock domain
//  reset      in   1  asynchronous, active-high reset
//  H_out1     in   2  hour tens digit from clock core (0..2)
//  H_out0     in   4  hour units digit (0..9)
//  M_out1     in   4  minute tens digit (0..5)
//  M_out0     in   4  minute units digit (0..9)
//  S_out1     in   4  second tens digit (0..5)
//  S_out0     in   4  second units digit (0..9)
//  Alarm      in   1  alarm active from clock core
//  an_n       out  6  digit enables, active low; bit i = digit index i
//  seg_n      out  7  segments {g,f,e,d,c,b,a}, active low
//  dp_n       out  1  decimal point, active low
//  alarm_led  out  1  registered copy of Alarm (1-cycle latency)
// BEHAVIOUR
//  Reset: an_n=6'h3F, seg_n=7'h7F, dp_n=1, alarm_led=0; div=0, idx=0, frame=0, blink=0, snapshot all 0.
//  Divider div counts 0..SCAN_DIV-1, wraps; tick = (div==SCAN_DIV-1).
//  Digit index idx: 0=S_out0, 1=S_out1, 2=M_out0, 3=M_out1, 4=H_out0, 5=H_out1; advances on tick, 5->0 wraps.
//  Snapshot: on a tick where idx wraps 5->0, all six digits and Alarm are captured into snap regs.
//  Outputs registered: on every tick, an_n/seg_n/dp_n load the pattern for the NEW idx; at wrap they
//   use the just-captured (live input) values, so no stale frame at idx 0. Between ticks, outputs hold.
//  an_n: only bit idx low; all high when blanked.
//  Decode: 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 6=7'h02 7=7'h78 8=7'h00 9=7'h10.
//  Range check: H_out1>2, M_out1>5, S_out1>5, any units digit>9 -> dash 7'h3F (g only).
//  dp_n=0 at idx 2 and 4 (HH.MM.SS separators), else 1; forced 1 when blanked.
//  Blink: frame counter increments on each wrap; at BLINK_FRAMES-1 it wraps to 0 and blink toggles.
//   If snap_alarm=1 and blink=1 -> display blanked (an_n=6'h3F, dp_n=1).
//   If snap_alarm=0 at a capture -> blink and frame cleared same edge; display steady.
//  Input changes between captures have no effect on an_n/seg_n until next wrap.
//  Reset asserted mid-frame: all state returns to reset values immediately (async); scan restarts at idx 0.
// CONFIGURATION
//  DISP_LEADING_ZERO_BLANK_EN defined: at idx 5, if snap H_out1==0, an_n stays 6'h3F for that slot
//   (hour tens suppressed, e.g. " 9.05.07"). Undefined: hour tens shows '0' (7'h40).
// STRUCTURE
//  Package clock_disp_pkg: NUM_DIGITS=6, SEG_* decode constants incl. SEG_DASH/SEG_OFF, digit-index
//   localparams (IDX_S0..IDX_H1), DP mask 6'b010100.
//  Sub-module seg7_decoder: combinational {4-bit digit, 4-bit max} -> 7-bit seg_n (dash when >max).
//  Top: divider, idx/frame/blink counters, snapshot regs, output regs.
// TESTING (SCAN_DIV=2, BLINK_FRAMES=2)
//  Reset 3 cycles, inputs 12:34:56 -> after reset an_n=6'h3F, seg_n=7'h7F; after first wrap
//   slots show 6,5,4,3,2,1 with an_n walking 111110..011111, dp_n=0 only at idx 2,4.
//  Change S_out0 6->7 at idx 2 -> idx 3..5 unaffected; S_out0 shows 7'h78 only after next wrap.
//  M_out1=4'd7 captured -> idx 3 seg_n=7'h3F (dash); H_out1=2'd3 -> idx 5 dash.
//  Alarm=1 held -> frames alternate 2 lit / 2 blanked (an_n=6'h3F); Alarm->0 -> steady from next frame;
//   alarm_led follows Alarm 1 cycle later.
//  Assert reset at idx 3 mid-slot -> outputs immediately 6'h3F/7'h7F/1; scan resumes at idx 0.
//  With DISP_LEADING_ZERO_BLANK_EN, 09:05:07 -> idx 5 slot an_n=6'h3F; without it, seg_n=7'h40 at idx 5.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed 7-segment clock display: segment codes (active low),
// digit-slot indices, decimal-point mask and per-slot digit range limits.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [2:0] IDX_S0 = 3'd0;
    localparam logic [2:0] IDX_S1 = 3'd1;
    localparam logic [2:0] IDX_M0 = 3'd2;
    localparam logic [2:0] IDX_M1 = 3'd3;
    localparam logic [2:0] IDX_H0 = 3'd4;
    localparam logic [2:0] IDX_H1 = 3'd5;

    localparam logic [5:0] DP_MASK = 6'b010100;
    localparam logic [5:0] AN_OFF  = 6'h3F;

    // Largest legal value for the digit shown in a given slot.
    function automatic logic [3:0] digit_max(input logic [2:0] idx);
        case (idx)
            IDX_S1, IDX_M1: return 4'd5;
            IDX_H1:         return 4'd2;
            default:        return 4'd9;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decode {g,f,e,d,c,b,a}; shows a dash when the
// digit exceeds the slot's maximum. Zero latency, no flow control.
module seg7_decoder
    import clock_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] max_val,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        if (digit <= max_val) begin
            case (digit)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/clock_display_driver.sv
// 6-digit multiplexed common-anode display driver: digits frozen per frame, alarm blinks display;
// outputs registered, update once per SCAN_DIV cycles. DISP_LEADING_ZERO_BLANK_EN hides a zero hour tens.
module clock_display_driver
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    input  logic [3:0] S_out1,
    input  logic [3:0] S_out0,
    input  logic       Alarm,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       alarm_led
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES) + 1;

    logic [DW-1:0]      div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic               blink_q, blink_d;
    logic [5:0][3:0]    snap_q, snap_d;
    logic               snap_alarm_q, snap_alarm_d;
    logic [5:0]         an_n_q, an_n_d;
    logic [6:0]         seg_n_q, seg_n_d;
    logic               dp_n_q, dp_n_d;
    logic               alarm_led_q;

    logic               tick, wrap, blank, src_alarm;
    logic [2:0]         nidx;
    logic [5:0][3:0]    live, src;
    logic [3:0]         dec_digit, dec_max;
    logic [6:0]         dec_seg;

    assign live = {{2'b00, H_out1}, H_out0, M_out1, M_out0, S_out1, S_out0};

    seg7_decoder u_dec (
        .digit   (dec_digit),
        .max_val (dec_max),
        .seg_n   (dec_seg)
    );

    always_comb begin
        div_d        = div_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        blink_d      = blink_q;
        snap_d       = snap_q;
        snap_alarm_d = snap_alarm_q;
        an_n_d       = an_n_q;
        seg_n_d      = seg_n_q;
        dp_n_d       = dp_n_q;

        tick   = (div_q == DW'(SCAN_DIV - 1));
        wrap   = tick && (idx_q == IDX_H1);
        nidx   = wrap ? IDX_S0 : idx_q + 3'd1;
        div_d  = tick ? '0 : div_q + DW'(1);

        if (tick) begin
            idx_d = nidx;
        end

        if (wrap) begin
            snap_d       = live;
            snap_alarm_d = Alarm;
            if (!Alarm) begin
                frame_d = '0;
                blink_d = 1'b0;
            end else if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        // At the wrap edge the freshly captured values drive slot 0, not last frame's snapshot.
        src       = wrap ? live  : snap_q;
        src_alarm = wrap ? Alarm : snap_alarm_q;
        blank     = src_alarm && blink_d;

        dec_digit = src[nidx];
        dec_max   = digit_max(nidx);

        if (tick) begin
            seg_n_d = dec_seg;
            if (blank) begin
                an_n_d = AN_OFF;
                dp_n_d = 1'b1;
            end else begin
                an_n_d = ~(6'b000001 << nidx);
                dp_n_d = ~DP_MASK[nidx];
            end
`ifdef DISP_LEADING_ZERO_BLANK_EN
            if (nidx == IDX_H1 && src[IDX_H1] == 4'd0) begin
                an_n_d  = AN_OFF;
                seg_n_d = SEG_OFF;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q        <= '0;
            idx_q        <= IDX_S0;
            frame_q      <= '0;
            blink_q      <= 1'b0;
            snap_q       <= '0;
            snap_alarm_q <= 1'b0;
            an_n_q       <= AN_OFF;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            alarm_led_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            blink_q      <= blink_d;
            snap_q       <= snap_d;
            snap_alarm_q <= snap_alarm_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            alarm_led_q  <= Alarm;
        end
    end

    assign an_n      = an_n_q;
    assign seg_n     = seg_n_q;
    assign dp_n      = dp_n_q;
    assign alarm_led = alarm_led_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver with SCAN_DIV=2 (one slot per 2 cycles, 12-cycle frame)
// and BLINK_FRAMES=2; expected patterns are hand-derived segment codes.
module tb_clock_display_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] H_out1 = 2'd1;
    logic [3:0] H_out0 = 4'd2;
    logic [3:0] M_out1 = 4'd3;
    logic [3:0] M_out0 = 4'd4;
    logic [3:0] S_out1 = 4'd5;
    logic [3:0] S_out0 = 4'd6;
    logic       Alarm = 1'b0;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       alarm_led;

    int total  = 0;
    int passed = 0;

    clock_display_driver #(.SCAN_DIV(2), .BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .H_out1    (H_out1),
        .H_out0    (H_out0),
        .M_out1    (M_out1),
        .M_out0    (M_out0),
        .S_out1    (S_out1),
        .S_out0    (S_out0),
        .Alarm     (Alarm),
        .an_n      (an_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .alarm_led (alarm_led)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] ea, input logic [6:0] es, input logic ed);
        total++;
        assert ({an_n, seg_n, dp_n} === {ea, es, ed}) begin
            passed++;
        end else begin
            $error("FAIL %s: an_n/seg_n/dp_n got %h/%h/%b expected %h/%h/%b", tag, an_n, seg_n, dp_n, ea, es, ed);
        end
    endtask

    task automatic check_an(input string tag, input logic [5:0] ea, input logic ed);
        total++;
        assert ({an_n, dp_n} === {ea, ed}) begin
            passed++;
        end else begin
            $error("FAIL %s: an_n/dp_n got %h/%b expected %h/%b", tag, an_n, dp_n, ea, ed);
        end
    endtask

    task automatic check_led(input string tag, input logic e);
        total++;
        assert (alarm_led === e) begin
            passed++;
        end else begin
            $error("FAIL %s: alarm_led got %b expected %b", tag, alarm_led, e);
        end
    endtask

    initial begin
        // Reset held 3 cycles with 12:34:56 on the inputs
        step(3);
        check("reset_out", 6'h3F, 7'h7F, 1'b1);
        check_led("reset_led", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // First wrap, then walk the frame
        step(12); check("f1_idx0", 6'h3E, 7'h02, 1'b1);
        step(2);  check("f1_idx1", 6'h3D, 7'h12, 1'b1);
        step(2);  check("f1_idx2", 6'h3B, 7'h19, 1'b0);
        S_out0 = 4'd7;
        step(2);  check("f1_idx3", 6'h37, 7'h30, 1'b1);
        step(2);  check("f1_idx4", 6'h2F, 7'h24, 1'b0);
        step(2);  check("f1_idx5", 6'h1F, 7'h79, 1'b1);
        step(2);  check("f2_idx0_new_s0", 6'h3E, 7'h78, 1'b1);

        // Out-of-range digits only appear after the next capture
        M_out1 = 4'd7;
        H_out1 = 2'd3;
        step(6);  check("f2_idx3_frozen", 6'h37, 7'h30, 1'b1);
        step(4);  check("f2_idx5_frozen", 6'h1F, 7'h79, 1'b1);
        step(2);  check("f3_idx0", 6'h3E, 7'h78, 1'b1);
        step(6);  check("f3_idx3_dash", 6'h37, 7'h3F, 1'b1);
        step(4);  check("f3_idx5_dash", 6'h1F, 7'h3F, 1'b1);
        M_out1 = 4'd3;
        H_out1 = 2'd1;

        // Alarm blink: lit, blanked, blanked, then steady after release
        Alarm = 1'b1;
        check_led("led_before", 1'b0);
        step(1);  check_led("led_after", 1'b1);
        step(1);  check("alm_fA_lit", 6'h3E, 7'h78, 1'b1);
        step(12); check_an("alm_fB_blank", 6'h3F, 1'b1);
        step(6);  check_an("alm_fB_idx3_blank", 6'h3F, 1'b1);
        step(6);  check_an("alm_fC_blank", 6'h3F, 1'b1);
        Alarm = 1'b0;
        check_led("led_hold", 1'b1);
        step(1);  check_led("led_clear", 1'b0);
        step(5);  check_an("alm_fC_idx3_still_blank", 6'h3F, 1'b1);
        step(6);  check("alm_off_lit", 6'h3E, 7'h78, 1'b1);
        step(12); check("alm_off_steady", 6'h3E, 7'h78, 1'b1);

        // Asynchronous reset in the middle of slot 3
        step(6);  check("pre_rst_idx3", 6'h37, 7'h30, 1'b1);
        step(1);
        reset = 1'b1;
        #1;
        check("async_rst", 6'h3F, 7'h7F, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(2);  check("rst_idx1_zero_snap", 6'h3D, 7'h40, 1'b1);
        step(10); check("rst_wrap_idx0", 6'h3E, 7'h78, 1'b1);

        // 09:05:07 for hour-tens zero handling
        H_out1 = 2'd0; H_out0 = 4'd9;
        M_out1 = 4'd0; M_out0 = 4'd5;
        S_out1 = 4'd0; S_out0 = 4'd7;
        step(10); check("lz_old_idx5", 6'h1F, 7'h79, 1'b1);
        step(2);  check("lz_idx0", 6'h3E, 7'h78, 1'b1);
        step(8);  check("lz_idx4", 6'h2F, 7'h10, 1'b0);
        step(2);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        check("lz_idx5_blank", 6'h3F, 7'h7F, 1'b1);
`else
        check("lz_idx5_zero", 6'h1F, 7'h40, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
